// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W  = 4;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned STAT_W = 16;

  // R15 reads as the PC and is never forwarded.
  localparam logic [REG_W-1:0] PC_REG = 4'd15;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

  // Operand source for one E-stage read port; M beats W.
  function automatic fwd_sel_e fwd_select(
    input logic [REG_W-1:0] ra,
    input logic             rw_m,
    input logic [REG_W-1:0] wa_m,
    input logic             rw_w,
    input logic [REG_W-1:0] wa_w
  );
    fwd_sel_e sel;
    sel = FWD_RF;
    if (ra == PC_REG) begin
      sel = FWD_RF;
    end else if (rw_m && (wa_m == ra)) begin
      sel = FWD_MEM;
    end else if (rw_w && (wa_w == ra)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mul_stall_fsm.sv
// Holds a multiply in E for MUL_CYCLES cycles; a PC write in W aborts it.
module mul_stall_fsm
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic mul_op_i,
  input  logic pc_src_w_i,
  output logic mul_stall_o,
  output logic mul_abort_o
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 2);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_stall_o = 1'b0;
    mul_abort_o = 1'b0;
    case (state_q)
      MUL_IDLE: begin
        if (mul_op_i) begin
          mul_stall_o = 1'b1;
          cnt_d       = CNT_LOAD;
          state_d     = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        // A redirect from W kills the multiply without stalling further.
        if (pc_src_w_i) begin
          mul_abort_o = 1'b1;
          cnt_d       = '0;
          state_d     = MUL_IDLE;
        end else if (cnt_q != '0) begin
          mul_stall_o = 1'b1;
          cnt_d       = cnt_q - 1'b1;
        end else begin
          state_d = MUL_IDLE;
        end
      end
      default: begin
        state_d = MUL_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding, load/multiply stalls, flushes and a stall statistic.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  RA1D,
  input  logic [REG_W-1:0]  RA2D,
  input  logic [REG_W-1:0]  RA1E,
  input  logic [REG_W-1:0]  RA2E,
  input  logic [REG_W-1:0]  WA3E,
  input  logic [REG_W-1:0]  WA3M,
  input  logic [REG_W-1:0]  WA3W,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MulOpE,
  input  logic              PCWrPendingF,
  input  logic              PCSrcW,
  input  logic              BranchTakenD,
  input  logic              StatClr,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              BranchGoD,
  output logic [STAT_W-1:0] StallCount
);

  logic              ldr_stall;
  logic              mul_stall;
  logic              mul_abort;
  fwd_sel_e          fwd_a, fwd_b;
  logic [STAT_W-1:0] stat_q, stat_d;

  mul_stall_fsm #(
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul_fsm (
    .clk_i       (clk),
    .reset_i     (reset),
    .mul_op_i    (MulOpE),
    .pc_src_w_i  (PCSrcW),
    .mul_stall_o (mul_stall),
    .mul_abort_o (mul_abort)
  );

  always_comb begin
    fwd_a = fwd_select(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
    fwd_b = fwd_select(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
  end

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;

  // Load-use: the loaded value is not available until after M.
  assign ldr_stall = MemtoRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));

  assign StallF    = ldr_stall | PCWrPendingF | mul_stall;
  assign StallD    = ldr_stall | mul_stall;
  assign StallE    = mul_stall;
  assign BranchGoD = BranchTakenD & ~mul_stall;
  assign FlushD    = (PCWrPendingF | PCSrcW | BranchGoD) & ~mul_stall;
  assign FlushE    = ((ldr_stall | BranchGoD) & ~mul_stall) | mul_abort;

  // Saturating stall statistic; clear wins over increment.
  always_comb begin
    stat_d = stat_q;
    if (StatClr) begin
      stat_d = '0;
    end else if (StallD && (stat_q != '1)) begin
      stat_d = stat_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign StallCount = stat_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MUL_CYCLES, default 3, sets total E-stage cycles per multiply; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 RA1D, RA2D  input  4 each  source register numbers of the instruction in D.
REQ-005 RA1E, RA2E  input  4 each  source register numbers of the instruction in E.
REQ-006 WA3E, WA3M, WA3W  input  4 each  destination register numbers in E, M, W.
REQ-007 RegWriteE, RegWriteM, RegWriteW  input  1 each  register write enables in E, M, W; E is ungated, M and W are condition-gated.
REQ-008 MemtoRegE, MulOpE  input  1 each  E holds a load; E holds a valid multiply.
REQ-009 PCWrPendingF, PCSrcW, BranchTakenD  input  1 each  PC write in flight in D/E/M; PC write in W; early branch resolved taken.
REQ-010 StatClr  input  1  clears the stall statistic counter.
REQ-011 ForwardAE, ForwardBE  output  2 each  operand source: 00 register file, 01 W result, 10 M ALU result.
REQ-012 StallF, StallD, StallE, FlushD, FlushE  output  1 each  pipeline register hold and clear controls.
REQ-013 BranchGoD  output  1  qualified taken branch for the PC mux.
REQ-014 StallCount  output  16  saturating count of cycles with StallD=1.

Function
REQ-015 ForwardAE SHALL be 10 if RegWriteM and WA3M==RA1E, else 01 if RegWriteW and WA3W==RA1E, else 00; M has priority; RA1E==15 always gives 00. ForwardBE uses RA2E the same way.
REQ-016 ldrStall SHALL be MemtoRegE & RegWriteE & (RA1D==WA3E | RA2D==WA3E), combinational.
REQ-017 The multiply FSM SHALL have two states:
- IDLE & MulOpE: mulStall=1, load cnt=MUL_CYCLES-2, go BUSY.
- BUSY & cnt!=0: mulStall=1, decrement cnt.
- BUSY & cnt==0: mulStall=0, go IDLE.
REQ-018 A multiply SHALL therefore occupy E for exactly MUL_CYCLES cycles; back-to-back multiplies restart from IDLE with no gap cycle.
REQ-019 Stall outputs SHALL be:
- StallF = ldrStall | PCWrPendingF | mulStall.
- StallD = ldrStall | mulStall.
- StallE = mulStall.
REQ-020 BranchGoD SHALL be BranchTakenD & ~mulStall.
REQ-021 Flush outputs SHALL be:
- FlushD = (PCWrPendingF | PCSrcW | BranchGoD) & ~mulStall.
- FlushE = (ldrStall | BranchGoD) & ~mulStall.
REQ-022 PCSrcW while BUSY SHALL abort the multiply: next state IDLE, and FlushE=1 in that cycle.
REQ-023 StallCount SHALL increment each cycle StallD=1, hold at 0xFFFF, and clear to 0 on StallClr; clear has priority over increment.
REQ-024 All outputs other than StallCount and the FSM-derived mulStall SHALL be purely combinational functions of their inputs, with zero-cycle latency.

Reset
REQ-025 reset SHALL force FSM=IDLE, cnt=0 and StallCount=0 on the next edge; this overrides any in-progress multiply.
REQ-026 In the cycle after reset, with all inputs low, every output SHALL be 0.

Structure
REQ-027 The forward-select encodings (RF, WB, MEM) and the FSM state encoding SHALL live in the shared package hazard_pkg.
REQ-028 The multiply FSM and counter SHALL be one sub-module, mul_stall_fsm; forwarding, stall, flush and statistics logic stay in hazard_ctrl.

Verification
REQ-029 RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10; same with RegWriteM=0 -> 01; with RA1E=15 -> 00.
REQ-030 Load in E (MemtoRegE=1, RegWriteE=1, WA3E=5) with RA2D=5 -> StallF=StallD=FlushE=1 for one cycle, FlushD=0.
REQ-031 MUL_CYCLES=3, MulOpE held high -> StallE=1 for 2 cycles, 0 on the 3rd; a second multiply immediately behind it repeats the pattern with no gap.
REQ-032 BranchTakenD=1 during the first multiply cycle -> BranchGoD=0 and FlushD=FlushE=0; on the release cycle -> BranchGoD=FlushD=FlushE=1.
REQ-033 reset asserted mid-multiply -> StallE=0 on the next cycle and StallCount=0; PCSrcW asserted while BUSY -> FlushE=1 and FSM=IDLE.
REQ-034 StallD held high for 70000 cycles -> StallCount=0xFFFF; then StatClr=1 -> StallCount=0 on the next edge.
